// File: rtl/serial_frame_rx_if.sv
// Handshake bundle between a serial frame receiver and its stimulus/consumer side.
// The master side drives the line and the ready; the slave side is the receiver.
interface serial_frame_rx_if #(
   parameter int DATA_W = 4
);
   logic              bit_en;
   logic              serial_in;
   logic              data_ready;
   logic [DATA_W-1:0] data_out;
   logic              data_valid;
   logic              parity_err;
   logic              frame_err;
   logic              overrun;
   logic              busy;

   modport master (
      output bit_en, serial_in, data_ready,
      input  data_out, data_valid, parity_err, frame_err, overrun, busy
   );

   modport slave (
      input  bit_en, serial_in, data_ready,
      output data_out, data_valid, parity_err, frame_err, overrun, busy
   );
endinterface

// File: rtl/serial_frame_rx.sv
// Start/data/parity/stop deserialiser feeding a one-entry valid/ready output register.
// Line sampling advances only on bit_en cycles; the output handshake runs every clk.
module serial_frame_rx #(
   parameter int DATA_W     = 4,
   parameter int PARITY_EN  = 1,
   parameter int ODD_PARITY = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   serial_frame_rx_if.slave      rx
);
   localparam int CNT_W = $clog2(DATA_W);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_WAIT_HIGH
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0]  shift_q, shift_d;
   logic               par_q, par_d;

   logic [DATA_W-1:0]  data_q, data_d;
   logic               valid_q, valid_d;
   logic               perr_q, perr_d;
   logic               ferr_q, ferr_d;
   logic               overrun_q, overrun_d;

   logic               complete;
   logic               stop_bad;
   logic               parity_bad;
   logic               accept;

   // NOTE: every signal assigned here gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      shift_d  = shift_q;
      par_d    = par_q;
      complete = 1'b0;
      stop_bad = 1'b0;
      if (rx.bit_en) begin
         unique case (state_q)
            S_IDLE: begin
               if (!rx.serial_in) begin
                  state_d = S_DATA;
                  cnt_d   = '0;
               end
            end
            S_DATA: begin
               shift_d[cnt_q] = rx.serial_in;
               cnt_d          = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end
            end
            S_PARITY: begin
               par_d   = rx.serial_in;
               state_d = S_STOP;
            end
            S_STOP: begin
               complete = 1'b1;
               stop_bad = !rx.serial_in;
               state_d  = rx.serial_in ? S_IDLE : S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
               // A held-low line must go high before another start bit counts.
               if (rx.serial_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // Xor of data and parity bit is 0 for good even parity, 1 for good odd parity.
   assign parity_bad = (PARITY_EN != 0) && ((^shift_q ^ par_q) != (ODD_PARITY != 0));
   assign accept     = valid_q && rx.data_ready;

   always_comb begin
      data_d    = data_q;
      valid_d   = valid_q;
      perr_d    = perr_q;
      ferr_d    = ferr_q;
      overrun_d = 1'b0;
      if (complete && (!valid_q || accept)) begin
         data_d  = shift_q;
         perr_d  = parity_bad;
         ferr_d  = stop_bad;
         valid_d = 1'b1;
      end else begin
         if (accept) valid_d = 1'b0;
         overrun_d = complete;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         perr_q    <= perr_d;
         ferr_q    <= ferr_d;
         overrun_q <= overrun_d;
      end
   end

   assign rx.data_out   = data_q;
   assign rx.data_valid = valid_q;
   assign rx.parity_err = perr_q;
   assign rx.frame_err  = ferr_q;
   assign rx.overrun    = overrun_q;
   assign rx.busy       = (state_q != S_IDLE);

endmodule

// File: doc/serial_frame_rx.md
Name: serial_frame_rx

Overview:
- Downstream consumer of the universal shift register's serial_out stream.
- Detects a start bit, deserialises DATA_W data bits LSB-first, checks optional parity and the stop bit, then presents the word on a one-entry valid/ready output register.
- Feeds the parallel word and error flags to the next stage, which may stall.

Parameters:
DATA_W, 4, data bits per frame (matches the 4-bit shift register width); legal range 2..16
PARITY_EN, 1, 1 = parity bit follows the data bits; 0 = no parity bit
ODD_PARITY, 0, 0 = even parity (data bits plus parity bit have an even count of ones); 1 = odd parity

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
bit_en  input  1  sample strobe; serial_in is consumed only on cycles with bit_en=1 (tie high for one bit per clk)
serial_in  input  1  serial line; idles high
data_out  output  DATA_W  received word, LSB = first data bit received
data_valid  output  1  data_out and the error flags hold an unconsumed word
data_ready  input  1  consumer accepts the word when data_valid=1 and data_ready=1
parity_err  output  1  parity mismatch for the held word; qualified by data_valid
frame_err  output  1  stop bit sampled as 0 for the held word; qualified by data_valid
overrun  output  1  one-cycle pulse: a completed frame was dropped because the output register was full
busy  output  1  FSM is not in IDLE

Behaviour:
- Reset values:
  - data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0.
  - FSM=IDLE, bit counter=0, shift register=0.
- Reset mid-frame discards the partial frame and any held word. Reset takes priority over every other event.
- All FSM transitions happen only on bit_en=1 cycles. On bit_en=0 cycles, state, counter and shift register hold.
- The output handshake operates every cycle regardless of bit_en.
- FSM states and transitions:
  - IDLE: serial_in=0 → DATA with counter cleared. serial_in=1 → stay in IDLE.
  - DATA: shift serial_in into bit position counter, then increment the counter. After bit DATA_W-1: go to PARITY if PARITY_EN, else STOP.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: complete the frame (see below).
    - serial_in=1 → IDLE.
    - serial_in=0 → frame error, go to WAIT_HIGH.
  - WAIT_HIGH: stay until serial_in=1 is sampled, then go to IDLE. This prevents a broken or held-low line from being taken as a new start bit.
- There is no start-bit revalidation: a single 0 sample in IDLE commits to a frame.
- Frame completion happens in the STOP bit_en cycle. The word, parity_err and frame_err are registered into the output stage and visible the next clk.
  - Latency: data_valid rises 1 clk after the stop-bit sample.
  - The parity check covers the DATA_W data bits plus the parity bit under ODD_PARITY. parity_err is always 0 when PARITY_EN=0.
  - A frame with frame_err is still delivered; the consumer decides whether to discard it.
- Output handshake:
  - data_valid stays 1 and data_out/flags stay stable until data_valid and data_ready are both 1.
  - After an accept, data_valid drops the next clk unless a new frame completes in the same cycle.
- Simultaneous events:
  - Completion in the same cycle as an accept: the new word loads, data_valid stays 1, no overrun.
  - Completion while data_valid=1 and data_ready=0: the new word is dropped, the held word is untouched, overrun pulses high for exactly 1 clk.
- Back-to-back frames (stop bit immediately followed by a start bit) must be received with no idle bit between them.
- busy=1 in DATA, PARITY, STOP and WAIT_HIGH.

Test Plan:
- Nominal frame: DATA_W=4, PARITY_EN=1, even parity, bit_en=1, data_ready=1. Send line 1,1,0(start),1,0,1,1,1(parity),1(stop) → data_out=4'hD, data_valid high for exactly 1 clk, 1 clk after the stop sample; parity_err=0, frame_err=0.
- Parity error: same frame with parity bit 0 → data_out=4'hD, parity_err=1, frame_err=0. With ODD_PARITY=1, parity bit 0 gives parity_err=0.
- Frame error with line held low:
  - Stop bit 0 → data_out delivered with frame_err=1.
  - Keep serial_in=0 for 5 more clks → busy=1 throughout, no new frame.
  - serial_in=1 then one start bit → normal reception resumes.
- Backpressure and overrun:
  - data_ready=0, send 4'h3 then 4'hA back-to-back → data_out stays 4'h3, overrun pulses 1 clk at the second stop.
  - Raise data_ready → 4'h3 accepted, then data_valid=0.
- Simultaneous accept and complete: hold 4'h5 with data_ready=0. Raise data_ready exactly on the cycle the next frame (4'h9) samples its stop → data_valid stays 1, data_out=4'h9 next clk, overrun=0.
- bit_en gating and reset:
  - bit_en=1 every 3rd clk, frame 4'hC → correct word.
  - A second run asserts reset after 2 data bits → all outputs 0, FSM=IDLE.
  - A following clean frame 4'h6 is received correctly.
